gen_matrix_ctrl: RTL and testbench

- Sequences the SHAKE-128 Parse engine over all K×K entries of the Kyber matrix A (or A^T) for one seed rho.
- Issues per-entry start and index bytes, captures up to two accepted coefficients per cycle, caps each polynomial at exactly 256 coefficients, and drives a dual-lane write port into polynomial RAM.
- Sits between the top-level KeyGen/Encrypt sequencer and the Parse instance.

---
 rtl/gen_matrix_ctrl_pkg.sv | 26 ++
 rtl/gen_matrix_ctrl_coef_compact.sv | 38 +++
 rtl/gen_matrix_ctrl.sv | 170 +++++++++++++++++
 tb/tb_gen_matrix_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_matrix_ctrl_pkg.sv
// Shared Kyber constants and the state encoding for the matrix-generation controller.
//   KYBER_Q  : modulus; Parse only flags coefficients below this value as valid
//   KYBER_N  : coefficients per polynomial
//   KYBER_CW : coefficient width
//   IDLE..DONE / state_e : controller state encoding
package gen_matrix_ctrl_pkg;

    localparam int unsigned KYBER_Q  = 3329;
    localparam int unsigned KYBER_N  = 256;
    localparam int unsigned KYBER_CW = 12;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] NEXT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = IDLE,
        ST_START = START,
        ST_RUN   = RUN,
        ST_NEXT  = NEXT,
        ST_DONE  = DONE
    } state_e;

endpackage

// File: rtl/gen_matrix_ctrl_coef_compact.sv
// Two-in / two-out coefficient compaction with the per-polynomial cap.
// Ports:
//   i_first/i_second       : candidate coefficients from Parse
//   i_first_en/i_second_en : candidate valid flags (already gated to the RUN state)
//   i_cnt                  : coefficients already stored for this polynomial (0..N)
//   o_en0/o_data0          : lane 0 write (coefficient index i_cnt)
//   o_en1/o_data1          : lane 1 write (coefficient index i_cnt+1)
//   o_inc                  : number of coefficients actually written this cycle
module gen_matrix_ctrl_coef_compact
    import gen_matrix_ctrl_pkg::*;
#(
    parameter int unsigned N    = KYBER_N,
    parameter int unsigned CW   = KYBER_CW,
    parameter int unsigned CNTW = $clog2(N) + 1
) (
    input  logic [CW-1:0]   i_first,
    input  logic [CW-1:0]   i_second,
    input  logic            i_first_en,
    input  logic            i_second_en,
    input  logic [CNTW-1:0] i_cnt,
    output logic            o_en0,
    output logic            o_en1,
    output logic [CW-1:0]   o_data0,
    output logic [CW-1:0]   o_data1,
    output logic [1:0]      o_inc
);

    always_comb begin
        // Lane 0 always carries the earliest valid coefficient; lane 1 only the second
        // of a valid pair, so lane 1 can never be enabled alone.
        o_data0 = i_first_en ? i_first : i_second;
        o_data1 = i_second;
        o_en0   = (i_first_en | i_second_en) && (i_cnt < CNTW'(N));
        o_en1   = (i_first_en & i_second_en) && (i_cnt < CNTW'(N - 1));
        o_inc   = {1'b0, o_en0} + {1'b0, o_en1};
    end

endmodule

// File: rtl/gen_matrix_ctrl.sv
// Sequences SHAKE-128 Parse over all K*K entries of the Kyber matrix A (or A^T) and
// streams the accepted coefficients into polynomial RAM through two write lanes.
// Ports:
//   i_clk, i_rstn                     : clock, asynchronous active-low reset
//   i_start, i_transpose, i_rho       : request, A/A^T select and seed (latched at start)
//   o_busy, o_done, o_short           : status; o_short is sticky until the next start
//   o_parse_start/rho/i/j             : per-entry command to Parse
//   i_parse_first/second(_en), i_parse_done : coefficient stream from Parse
//   o_wr_en0/addr0/data0, o_wr_en1/addr1/data1 : registered RAM write lanes
module gen_matrix_ctrl
    import gen_matrix_ctrl_pkg::*;
#(
    parameter int unsigned K  = 2,
    parameter int unsigned N  = KYBER_N,
    parameter int unsigned CW = KYBER_CW,
    parameter int unsigned AW = $clog2(K * K) + $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_start,
    input  logic          i_transpose,
    input  logic [255:0]  i_rho,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_short,
    output logic          o_parse_start,
    output logic [255:0]  o_parse_rho,
    output logic [7:0]    o_parse_i,
    output logic [7:0]    o_parse_j,
    input  logic [CW-1:0] i_parse_first,
    input  logic [CW-1:0] i_parse_second,
    input  logic          i_parse_first_en,
    input  logic          i_parse_second_en,
    input  logic          i_parse_done,
    output logic          o_wr_en0,
    output logic [AW-1:0] o_wr_addr0,
    output logic [CW-1:0] o_wr_data0,
    output logic          o_wr_en1,
    output logic [AW-1:0] o_wr_addr1,
    output logic [CW-1:0] o_wr_data1
);

    localparam int unsigned RCW  = $clog2(K);
    localparam int unsigned PW   = $clog2(K * K);
    localparam int unsigned IW   = $clog2(N);
    localparam int unsigned CNTW = IW + 1;

    state_e          r_state, w_state_d;
    logic            r_transpose;
    logic [255:0]    r_rho;
    logic [RCW-1:0]  r_row, r_col;
    logic [CNTW-1:0] r_cnt;
    logic            r_short;
    logic            r_wr_en0, r_wr_en1;
    logic [AW-1:0]   r_wr_addr0, r_wr_addr1;
    logic [CW-1:0]   r_wr_data0, r_wr_data1;

    logic            w_run, w_last;
    logic [PW-1:0]   w_p;
    logic            w_en0, w_en1;
    logic [CW-1:0]   w_data0, w_data1;
    logic [1:0]      w_inc;

    assign w_run  = (r_state == ST_RUN);
    assign w_last = (r_row == RCW'(K - 1)) && (r_col == RCW'(K - 1));
    assign w_p    = PW'(r_row) * PW'(K) + PW'(r_col);

    // Enables are masked outside RUN so stray Parse activity never writes or counts.
    gen_matrix_ctrl_coef_compact #(
        .N    (N),
        .CW   (CW),
        .CNTW (CNTW)
    ) u_compact (
        .i_first     (i_parse_first),
        .i_second    (i_parse_second),
        .i_first_en  (i_parse_first_en & w_run),
        .i_second_en (i_parse_second_en & w_run),
        .i_cnt       (r_cnt),
        .o_en0       (w_en0),
        .o_en1       (w_en1),
        .o_data0     (w_data0),
        .o_data1     (w_data1),
        .o_inc       (w_inc)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_start) w_state_d = ST_START;
            ST_START: w_state_d = ST_RUN;
            ST_RUN:   if (i_parse_done) w_state_d = ST_NEXT;
            ST_NEXT:  w_state_d = w_last ? ST_DONE : ST_START;
            ST_DONE:  w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_transpose <= 1'b0;
            r_rho       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_cnt       <= '0;
            r_short     <= 1'b0;
            r_wr_en0    <= 1'b0;
            r_wr_en1    <= 1'b0;
            r_wr_addr0  <= '0;
            r_wr_addr1  <= '0;
            r_wr_data0  <= '0;
            r_wr_data1  <= '0;
        end else begin
            r_wr_en0   <= w_en0;
            r_wr_en1   <= w_en1;
            r_wr_addr0 <= AW'({w_p, r_cnt[IW-1:0]});
            // Lane 1 is only enabled while r_cnt < N-1, so the +1 never wraps.
            r_wr_addr1 <= AW'({w_p, r_cnt[IW-1:0] + IW'(1)});
            r_wr_data0 <= w_data0;
            r_wr_data1 <= w_data1;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_rho       <= i_rho;
                        r_transpose <= i_transpose;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_short     <= 1'b0;
                    end
                end
                ST_START: r_cnt <= '0;
                ST_RUN:   r_cnt <= r_cnt + CNTW'(w_inc);
                ST_NEXT: begin
                    if (r_cnt < CNTW'(N)) r_short <= 1'b1;
                    if (!w_last) begin
                        if (r_col == RCW'(K - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + RCW'(1);
                        end else begin
                            r_col <= r_col + RCW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_DONE);
    assign o_short       = r_short;
    assign o_parse_start = (r_state == ST_START);
    assign o_parse_rho   = r_rho;
    assign o_parse_i     = r_transpose ? 8'(r_row) : 8'(r_col);
    assign o_parse_j     = r_transpose ? 8'(r_col) : 8'(r_row);
    assign o_wr_en0      = r_wr_en0;
    assign o_wr_addr0    = r_wr_addr0;
    assign o_wr_data0    = r_wr_data0;
    assign o_wr_en1      = r_wr_en1;
    assign o_wr_addr1    = r_wr_addr1;
    assign o_wr_data1    = r_wr_data1;

endmodule

// File: tb/tb_gen_matrix_ctrl.sv
// Randomized bench for gen_matrix_ctrl: the bench plays the Parse engine and keeps a
// coefficient-stream model (ordered list of kept coefficients per entry, capped at N).
module tb_gen_matrix_ctrl;
    import gen_matrix_ctrl_pkg::*;

    localparam int unsigned K  = 2;
    localparam int unsigned N  = 256;
    localparam int unsigned CW = 12;
    localparam int unsigned AW = 10;

    localparam int MFULL = 0, MRAND = 1, MEDGE = 2, MSHORT = 3, MSEC10 = 4, MRST = 5;

    logic          i_clk, i_rstn, i_start, i_transpose;
    logic [255:0]  i_rho;
    logic          o_busy, o_done, o_short, o_parse_start;
    logic [255:0]  o_parse_rho;
    logic [7:0]    o_parse_i, o_parse_j;
    logic [CW-1:0] i_parse_first, i_parse_second;
    logic          i_parse_first_en, i_parse_second_en, i_parse_done;
    logic          o_wr_en0, o_wr_en1;
    logic [AW-1:0] o_wr_addr0, o_wr_addr1;
    logic [CW-1:0] o_wr_data0, o_wr_data1;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    gen_matrix_ctrl #(.K(K), .N(N), .CW(CW), .AW(AW)) u_dut (
        .i_clk             (i_clk),
        .i_rstn            (i_rstn),
        .i_start           (i_start),
        .i_transpose       (i_transpose),
        .i_rho             (i_rho),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_short           (o_short),
        .o_parse_start     (o_parse_start),
        .o_parse_rho       (o_parse_rho),
        .o_parse_i         (o_parse_i),
        .o_parse_j         (o_parse_j),
        .i_parse_first     (i_parse_first),
        .i_parse_second    (i_parse_second),
        .i_parse_first_en  (i_parse_first_en),
        .i_parse_second_en (i_parse_second_en),
        .i_parse_done      (i_parse_done),
        .o_wr_en0          (o_wr_en0),
        .o_wr_addr0        (o_wr_addr0),
        .o_wr_data0        (o_wr_data0),
        .o_wr_en1          (o_wr_en1),
        .o_wr_addr1        (o_wr_addr1),
        .o_wr_data1        (o_wr_data1)
    );

    // One record per cycle in which at least one coefficient is expected to be written.
    typedef struct {
        logic          en1;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [CW-1:0] d0;
        logic [CW-1:0] d1;
    } wr_t;

    wr_t          exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           n_obs_wr = 0;
    int           n_exp_wr = 0;
    int           n_done = 0;
    logic [255:0] m_rho;
    bit           m_tr;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge i_clk) begin : mon
        wr_t w;
        if (o_done) n_done++;
        if (o_wr_en1) check("lane1_needs_lane0", 256'(o_wr_en0), 256'(1));
        if (o_wr_en0) begin
            check("wr_expected", 256'(exp_q.size() != 0), 256'(1));
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("wr_addr0", 256'(o_wr_addr0), 256'(w.a0));
                check("wr_data0", 256'(o_wr_data0), 256'(w.d0));
                check("wr_en1", 256'(o_wr_en1), 256'(w.en1));
                if (w.en1) begin
                    check("wr_addr1", 256'(o_wr_addr1), 256'(w.a1));
                    check("wr_data1", 256'(o_wr_data1), 256'(w.d1));
                end
            end
            n_obs_wr += 1 + int'(o_wr_en1);
        end
    end

    task automatic set_idle();
        i_parse_first_en  = 1'b0;
        i_parse_second_en = 1'b0;
        i_parse_done      = 1'b0;
    endtask

    // Drives one RUN cycle as Parse and records what the RAM should see.
    task automatic drive_cycle(input int e, input bit fe, input bit se, input bit dn,
                               inout int k);
        wr_t           r;
        int            kept;
        int            nv;
        logic [CW-1:0] v[2];
        kept = 0;
        nv = 0;
        r.en1 = 1'b0; r.a0 = '0; r.a1 = '0; r.d0 = '0; r.d1 = '0;
        i_parse_first     = CW'($urandom_range(KYBER_Q - 1, 0));
        i_parse_second    = CW'($urandom_range(KYBER_Q - 1, 0));
        i_parse_first_en  = fe;
        i_parse_second_en = se;
        i_parse_done      = dn;
        if (fe) begin v[nv] = i_parse_first;  nv++; end
        if (se) begin v[nv] = i_parse_second; nv++; end
        for (int i = 0; i < nv; i++) begin
            if (k < int'(N)) begin
                if (kept == 0) begin
                    r.a0 = AW'(e * int'(N) + k);
                    r.d0 = v[i];
                end else begin
                    r.en1 = 1'b1;
                    r.a1 = AW'(e * int'(N) + k);
                    r.d1 = v[i];
                end
                kept++;
            end
            k++;
        end
        if (kept > 0) begin
            exp_q.push_back(r);
            n_exp_wr += kept;
        end
        @(posedge i_clk); #1;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"}, 256'(o_busy), 256'(0));
        check({pfx, "_done"}, 256'(o_done), 256'(0));
        check({pfx, "_short"}, 256'(o_short), 256'(0));
        check({pfx, "_pstart"}, 256'(o_parse_start), 256'(0));
        check({pfx, "_rho"}, o_parse_rho, 256'(0));
        check({pfx, "_pi"}, 256'({o_parse_i, o_parse_j}), 256'(0));
        check({pfx, "_wen"}, 256'({o_wr_en0, o_wr_en1}), 256'(0));
        check({pfx, "_wbus"}, 256'({o_wr_addr0, o_wr_addr1, o_wr_data0, o_wr_data1}),
              256'(0));
    endtask

    task automatic run_entry(input int e, input int mode, inout bit short_acc, output bit ok);
        bit seen;
        int k;
        int row;
        int col;
        seen = 1'b0;
        k = 0;
        row = e / int'(K);
        col = e % int'(K);
        ok = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge i_clk);
            seen = o_parse_start;
        end
        check("parse_start_seen", 256'(seen), 256'(1));
        if (!seen) return;
        check("parse_i", 256'(o_parse_i), 256'(m_tr ? row : col));
        check("parse_j", 256'(o_parse_j), 256'(m_tr ? col : row));
        check("parse_rho", o_parse_rho, m_rho);
        check("busy_in_entry", 256'(o_busy), 256'(1));
        check("short_sticky", 256'(o_short), 256'(short_acc));
        @(posedge i_clk); #1;
        case (mode)
            MFULL: for (int c = 0; c < 128; c++) drive_cycle(e, 1'b1, 1'b1, c == 127, k);
            MEDGE: begin
                for (int c = 0; c < 127; c++) drive_cycle(e, 1'b1, 1'b1, 1'b0, k);
                drive_cycle(e, 1'b1, 1'b0, 1'b0, k);
                drive_cycle(e, 1'b1, 1'b1, 1'b1, k);
            end
            MSHORT: for (int c = 0; c < 100; c++) drive_cycle(e, 1'b1, 1'b1, c == 99, k);
            MSEC10: begin
                for (int c = 0; c < 5; c++) drive_cycle(e, 1'b1, 1'b1, 1'b0, k);
                drive_cycle(e, 1'b0, 1'b1, 1'b0, k);
                for (int c = 0; c < 122; c++) drive_cycle(e, 1'b1, 1'b1, 1'b0, k);
                drive_cycle(e, 1'b1, 1'b0, 1'b1, k);
            end
            MRAND: begin
                int extra;
                bit dn;
                extra = int'($urandom_range(6, 0));
                dn = 1'b0;
                for (int c = 0; c < 1000 && !dn; c++) begin
                    bit fe;
                    bit se;
                    fe = ($urandom_range(3, 0) != 0);
                    se = ($urandom_range(3, 0) != 0);
                    dn = (k + int'(fe) + int'(se) >= int'(N) + extra) || (c == 999);
                    // A start request while busy must be ignored.
                    if (c == 3) begin
                        i_start     = 1'b1;
                        i_rho       = ~m_rho;
                        i_transpose = ~m_tr;
                    end
                    drive_cycle(e, fe, se, dn, k);
                    i_start = 1'b0;
                end
            end
            MRST: begin
                for (int c = 0; c < 20; c++) drive_cycle(e, 1'b1, 1'b1, 1'b0, k);
                i_rstn = 1'b0;
                exp_q.delete();
                @(negedge i_clk);
                check_all_zero("midrst");
                @(posedge i_clk); #1;
                i_rstn = 1'b1;
                repeat (3) @(negedge i_clk);
                check("idle_after_rst_busy", 256'(o_busy), 256'(0));
                check("idle_after_rst_pstart", 256'(o_parse_start), 256'(0));
                set_idle();
                @(posedge i_clk); #1;
                return;
            end
            default: ;
        endcase
        // Parse activity during NEXT must be ignored.
        i_parse_first_en  = 1'($urandom_range(1, 0));
        i_parse_second_en = 1'($urandom_range(1, 0));
        i_parse_done      = 1'b1;
        @(posedge i_clk); #1;
        set_idle();
        if (k < int'(N)) short_acc = 1'b1;
        ok = 1'b1;
    endtask

    task automatic run_matrix(input bit tr, input logic [255:0] rho,
                              input int m0, input int m1, input int m2, input int m3);
        int modes[4];
        bit short_acc;
        bit ok;
        modes = '{m0, m1, m2, m3};
        short_acc = 1'b0;
        ok = 1'b1;
        n_done = 0;
        n_obs_wr = 0;
        n_exp_wr = 0;
        m_tr = tr;
        m_rho = rho;
        i_start = 1'b1;
        i_transpose = tr;
        i_rho = rho;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_transpose = ~tr;
        i_rho = {8{$urandom}};
        for (int e = 0; e < int'(K * K) && ok; e++) run_entry(e, modes[e], short_acc, ok);
        if (ok) begin
            @(negedge i_clk);
            check("done_pulse", 256'(o_done), 256'(1));
            check("busy_in_done", 256'(o_busy), 256'(1));
            check("short_at_done", 256'(o_short), 256'(short_acc));
            @(negedge i_clk);
            check("done_one_cycle", 256'(o_done), 256'(0));
            check("busy_after_done", 256'(o_busy), 256'(0));
            check("write_count", 256'(n_obs_wr), 256'(n_exp_wr));
            check("exp_queue_drained", 256'(exp_q.size()), 256'(0));
            check("done_count", 256'(n_done), 256'(1));
        end
    endtask

    initial begin
        i_rstn = 1'b0;
        i_start = 1'b0;
        i_transpose = 1'b0;
        i_rho = '0;
        i_parse_first = '0;
        i_parse_second = '0;
        set_idle();
        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        @(posedge i_clk); #1;

        run_matrix(1'b0, 256'h1, MFULL, MFULL, MFULL, MFULL);
        run_matrix(1'b1, 256'h1, MFULL, MFULL, MFULL, MFULL);
        run_matrix(1'b0, {8{$urandom}}, MEDGE, MSEC10, MSHORT, MRAND);
        run_matrix(1'b1, {8{$urandom}}, MFULL, MRAND, MRAND, MRAND);
        run_matrix(1'b0, {8{$urandom}}, MFULL, MFULL, MRST, MFULL);
        run_matrix(1'b0, {8{$urandom}}, MFULL, MRAND, MEDGE, MFULL);
        run_matrix(1'b1, {8{$urandom}}, MRAND, MRAND, MRAND, MRAND);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
